// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared class codes, function codes and FSM states for the ALU arbiter
package alu_pkg;

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_CMP   = 2'b10;
  localparam logic [1:0] CLS_SHIFT = 2'b11;

  localparam logic [3:0] FUN_ADD = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    CAPT = 2'b10,
    RESP = 2'b11
  } state_t;

  function automatic logic [1:0] fun_class(input logic [3:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// rtl/alu_rr_arb2.sv - two-input round-robin grant with a priority pointer register
module alu_rr_arb2
  import alu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant,
  output logic       o_grant_id
);

  // r_ptr names the requester that wins a tie
  logic r_ptr;
  logic [1:0] w_grant;

  always_comb begin
    w_grant = 2'b00;
    if (!r_ptr) begin
      if (i_req[0])      w_grant = 2'b01;
      else if (i_req[1]) w_grant = 2'b10;
    end else begin
      if (i_req[1])      w_grant = 2'b10;
      else if (i_req[0]) w_grant = 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_advance) begin
      r_ptr <= ~w_grant[1];
    end
  end

  assign o_grant    = w_grant;
  assign o_grant_id = w_grant[1];

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// rtl/alu_arbiter_ctrl.sv - shares one ALU between two requesters with a tagged response channel
module alu_arbiter_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [3:0]           req0_fun,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [3:0]           req1_fun,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 rsp_carry,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_fun,
  input  logic [2*WIDTH-1:0]   arith_out,
  input  logic                 carry_out,
  input  logic                 arith_flag,
  input  logic [WIDTH-1:0]     logic_out,
  input  logic                 logic_flag,
  input  logic [WIDTH-1:0]     cmp_out,
  input  logic                 cmp_flag,
  input  logic [WIDTH-1:0]     shift_out,
  input  logic                 shift_flag,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         w_grant;
  logic               w_grant_id;
  logic               w_hs;
  logic [3:0]         w_fun;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;

  logic [3:0]         r_fun;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_id;
  logic [2*WIDTH-1:0] r_rsp_data;
  logic               r_rsp_carry;
  logic               r_rsp_err;
  logic [CNT_W-1:0]   r_op_count;

  alu_rr_arb2 u_arb (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_req      (req_valid),
    .i_advance  (w_hs),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 2'b00;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    w_hs         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        // no accepts while reset is held, so nothing is lost on release
        if (!RST) begin
          req_ready = w_grant;
          w_hs      = |w_grant;
        end
        if (w_hs) w_state_next = EXEC;
      end
      EXEC: w_state_next = CAPT;
      CAPT: w_state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_fun = w_grant_id ? req1_fun : req0_fun;
  assign w_a   = w_grant_id ? req1_a   : req0_a;
  assign w_b   = w_grant_id ? req1_b   : req0_b;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fun <= FUN_ADD;
      r_a   <= '0;
      r_b   <= '0;
      r_id  <= 1'b0;
    end else if (w_hs) begin
      r_fun <= w_fun;
      r_a   <= w_a;
      r_b   <= w_b;
      r_id  <= w_grant_id;
    end
  end

  // The ALU sees the issue registers at all times; only the CAPT sample is kept
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (r_state == CAPT) begin
      r_rsp_carry <= 1'b0;
      case (fun_class(r_fun))
        CLS_ARITH: begin
          r_rsp_data  <= arith_out;
          r_rsp_carry <= carry_out;
          r_rsp_err   <= ~arith_flag;
        end
        CLS_LOGIC: begin
          r_rsp_data <= {{WIDTH{1'b0}}, logic_out};
          r_rsp_err  <= ~logic_flag;
        end
        CLS_CMP: begin
          r_rsp_data <= {{WIDTH{1'b0}}, cmp_out};
          r_rsp_err  <= ~cmp_flag;
        end
        default: begin
          r_rsp_data <= {{WIDTH{1'b0}}, shift_out};
          r_rsp_err  <= ~shift_flag;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op_count <= '0;
    end else if (r_state == RESP && rsp_ready && r_op_count != '1) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_fun   = r_fun;
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign rsp_err   = r_rsp_err;
  assign op_count  = r_op_count;

endmodule
